// File: rtl/mdio_master_frame.sv
// Clause-22 MDIO master: serialises one 64-bit read or write frame per command.
// eth_mdc is divided down from sys_clk; eth_mdio is driven or released to Z.
//   state  | meaning
//   IDLE   | waiting for op_exec, MDC high, bus released
//   PRE    | bits 0-31, preamble ones
//   HDR    | bits 32-45, ST/OP/PHYAD/REGAD
//   TA     | bits 46-47, turnaround (error sampled on bit 47 for reads)
//   DATA   | bits 48-63, write data out or read data in
//   DONE   | one-cycle completion, results published
module mdio_master_frame #(
  parameter int CLK_DIV = 10
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        op_exec,
  input  logic        op_rh_wl,
  input  logic [4:0]  op_phy_addr,
  input  logic [4:0]  op_reg_addr,
  input  logic [15:0] op_wr_data,
  output logic        op_busy,
  output logic        op_done,
  output logic [15:0] op_rd_data,
  output logic        op_rd_err,
  output logic        eth_mdc,
  inout  wire         eth_mdio
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE} state_t;

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_FIRST = CW'(CLK_DIV - 2);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    bit_q, bit_d;
  logic          mdc_q, mdc_d;
  logic          oe_q, oe_d;
  logic          out_q, out_d;
  logic          rh_q, rh_d;
  logic [4:0]    phy_q, phy_d;
  logic [4:0]    reg_q, reg_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   shift_q, shift_d;
  logic          pend_q, pend_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          rd_err_q, rd_err_d;

  logic [63:0]   frame;
  logic          accept, tick, fall, rise;

  assign frame   = {32'hffff_ffff, 2'b01, (rh_q ? 2'b10 : 2'b01), phy_q, reg_q, 2'b10, wdata_q};
  assign op_busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign op_done = (state_q == S_DONE);
  assign accept  = op_exec && !op_busy;
  assign tick    = (cnt_q == '0);
  // bit_q reaches 64 after the last rising edge; the divider stops there
  assign fall    = op_busy && (bit_q != 7'd64) && tick && mdc_q;
  assign rise    = op_busy && (bit_q != 7'd64) && tick && !mdc_q;

  assign eth_mdc    = mdc_q;
  assign eth_mdio   = oe_q ? out_q : 1'bz;
  assign op_rd_data = rd_data_q;
  assign op_rd_err  = rd_err_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      mdc_q     <= 1'b1;
      oe_q      <= 1'b0;
      out_q     <= 1'b1;
      rh_q      <= 1'b0;
      phy_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      shift_q   <= '0;
      pend_q    <= 1'b0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      mdc_q     <= mdc_d;
      oe_q      <= oe_d;
      out_q     <= out_d;
      rh_q      <= rh_d;
      phy_q     <= phy_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      shift_q   <= shift_d;
      pend_q    <= pend_d;
      rd_data_q <= rd_data_d;
      rd_err_q  <= rd_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    mdc_d     = mdc_q;
    oe_d      = oe_q;
    out_d     = out_q;
    rh_d      = rh_q;
    phy_d     = phy_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    shift_d   = shift_q;
    pend_d    = pend_q;
    rd_data_d = rd_data_q;
    rd_err_d  = rd_err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        oe_d    = 1'b0;
        if (accept) begin
          state_d = S_PRE;
          cnt_d   = DIV_FIRST;
          bit_d   = '0;
          mdc_d   = 1'b1;
          pend_d  = 1'b0;
          rh_d    = op_rh_wl;
          phy_d   = op_phy_addr;
          reg_d   = op_reg_addr;
          wdata_d = op_wr_data;
        end
      end
      default: begin
        if (bit_q == 7'd64) begin
          state_d = S_DONE;
          oe_d    = 1'b0;
          if (rh_q) begin
            rd_data_d = shift_q;
            rd_err_d  = pend_q;
          end else begin
            rd_err_d  = 1'b0;
          end
        end else begin
          cnt_d = tick ? DIV_LAST : cnt_q - CW'(1);
          if (tick) mdc_d = ~mdc_q;
        end
        if (fall) begin
          out_d = frame[6'd63 - bit_q[5:0]];
          oe_d  = !(rh_q && (bit_q >= 7'd46));
        end
        if (rise) begin
          bit_d = bit_q + 7'd1;
          if (rh_q && (bit_q == 7'd47)) pend_d  = eth_mdio;
          if (rh_q && (bit_q >= 7'd48)) shift_d = {shift_q[14:0], eth_mdio};
          if (bit_q == 7'd31) state_d = S_HDR;
          if (bit_q == 7'd45) state_d = S_TA;
          if (bit_q == 7'd47) state_d = S_DATA;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mdio_master_frame.sv
// Bench for mdio_master_frame: behavioural PHY slave on the bus, command-level model,
// directed table, corner sequences, random commands and a CLK_DIV=2 instance.
module tb_mdio_master_frame;
  localparam int CD1 = 10;
  localparam int CD2 = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        op_exec = 1'b0;
  logic        exec2 = 1'b0;
  logic        op_rh_wl = 1'b0;
  logic [4:0]  op_phy_addr = '0;
  logic [4:0]  op_reg_addr = '0;
  logic [15:0] op_wr_data = '0;
  logic        op_busy, op_done, op_rd_err, eth_mdc;
  logic [15:0] op_rd_data;
  logic        busy2, done2, err2, mdc2;
  logic [15:0] rd2;
  wire         mdio_bus;
  wire         mdio2;
  logic        slv_oe = 1'b0;
  logic        slv_val = 1'b1;

  pullup (mdio_bus);
  pullup (mdio2);
  assign mdio_bus = slv_oe ? slv_val : 1'bz;

  mdio_master_frame #(.CLK_DIV(CD1)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .op_exec(op_exec), .op_rh_wl(op_rh_wl),
    .op_phy_addr(op_phy_addr), .op_reg_addr(op_reg_addr), .op_wr_data(op_wr_data),
    .op_busy(op_busy), .op_done(op_done), .op_rd_data(op_rd_data), .op_rd_err(op_rd_err),
    .eth_mdc(eth_mdc), .eth_mdio(mdio_bus));

  mdio_master_frame #(.CLK_DIV(CD2)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .op_exec(exec2), .op_rh_wl(op_rh_wl),
    .op_phy_addr(op_phy_addr), .op_reg_addr(op_reg_addr), .op_wr_data(op_wr_data),
    .op_busy(busy2), .op_done(done2), .op_rd_data(rd2), .op_rd_err(err2),
    .eth_mdc(mdc2), .eth_mdio(mdio2));

  initial forever #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // behavioural PHY at address 4: hunts for 32 ones + ST, answers reads, stores writes
  int          sl_pos = -1;
  int          sl_ones = 0;
  logic [11:0] sl_hdr = '0;
  logic        sl_rd = 1'b0;
  logic [4:0]  sl_reg = '0;
  logic [15:0] sl_wd = '0;
  logic [15:0] sl_regs [32];
  logic        sl_b;
  logic        cap [$];
  logic        cap2 [$];

  always @(posedge eth_mdc or posedge sys_rst) begin
    if (sys_rst) begin
      sl_pos = -1; sl_ones = 0; sl_rd = 1'b0; slv_oe = 1'b0;
    end else begin
      sl_b = mdio_bus;
      cap.push_back(sl_b);
      if (sl_pos < 0) begin
        if (sl_b) sl_ones++;
        else begin
          if (sl_ones >= 32) sl_pos = 0;
          sl_ones = 0;
        end
      end else begin
        sl_pos++;
        if (sl_pos >= 2 && sl_pos <= 13) sl_hdr = {sl_hdr[10:0], sl_b};
        if (sl_pos == 13) begin
          sl_rd  = (sl_hdr[11:10] == 2'b10) && (sl_hdr[9:5] == 5'h04);
          sl_reg = sl_hdr[4:0];
        end
        if (sl_pos >= 16) sl_wd = {sl_wd[14:0], sl_b};
        if (sl_pos == 31) begin
          if (sl_hdr[11:10] == 2'b01 && sl_hdr[9:5] == 5'h04) sl_regs[sl_reg] = sl_wd;
          slv_oe = 1'b0; sl_rd = 1'b0; sl_pos = -1;
        end
      end
    end
  end

  always @(negedge eth_mdc) begin
    if (sl_rd) begin
      if (sl_pos == 14) begin slv_oe = 1'b1; slv_val = 1'b0; end
      else if (sl_pos >= 15 && sl_pos <= 30) slv_val = sl_regs[sl_reg][30 - sl_pos];
    end
  end

  always @(posedge mdc2) cap2.push_back(mdio2);

  int          n_tests = 0;
  int          n_fail = 0;
  int          t0 = 0;
  logic [15:0] m_regs [32];
  logic [15:0] m_rd = '0;

  typedef struct {
    logic        rh;
    logic [4:0]  pa;
    logic [4:0]  ra;
    logic [15:0] wd;
    logic [15:0] ed;
    logic        ee;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic sel_busy(input int w); return (w != 0) ? busy2 : op_busy; endfunction
  function automatic logic sel_done(input int w); return (w != 0) ? done2 : op_done; endfunction
  function automatic logic sel_mdc(input int w);  return (w != 0) ? mdc2 : eth_mdc;  endfunction

  function automatic logic [63:0] wr_frame(input logic [4:0] pa, input logic [4:0] ra,
                                           input logic [15:0] wd);
    return {32'hffff_ffff, 4'b0101, pa, ra, 2'b10, wd};
  endfunction

  task automatic model_cmd(input logic rh, input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] wd, output logic [15:0] ed, output logic ee);
    if (!rh) begin
      if (pa == 5'h04) m_regs[ra] = wd;
      ee = 1'b0;
    end else if (pa == 5'h04) begin
      m_rd = m_regs[ra]; ee = 1'b0;
    end else begin
      m_rd = 16'hffff; ee = 1'b1;
    end
    ed = m_rd;
  endtask

  // called at a negedge; that cycle becomes cycle 0 of the command
  task automatic drive_exec(input int w, input logic rh, input logic [4:0] pa,
                            input logic [4:0] ra, input logic [15:0] wd);
    op_rh_wl = rh; op_phy_addr = pa; op_reg_addr = ra; op_wr_data = wd;
    if (w != 0) begin exec2 = 1'b1; cap2.delete(); end
    else begin op_exec = 1'b1; cap.delete(); end
    t0 = cyc;
    @(negedge sys_clk);
    op_exec = 1'b0; exec2 = 1'b0;
  endtask

  task automatic run_frame(input string nm, input int w, input int cd, input int coll_at);
    int f1, f2;
    logic m, m_prev, busy_bad, got;
    f1 = -1; f2 = -1; m_prev = 1'b1; busy_bad = 1'b0; got = 1'b0;
    chk({nm, "_busy_cycle1"}, sel_busy(w), 1);
    for (int i = 0; i < 140 * cd; i++) begin
      if (sel_done(w)) begin got = 1'b1; break; end
      if (!sel_busy(w)) busy_bad = 1'b1;
      m = sel_mdc(w);
      if (m_prev && !m) begin
        if (f1 < 0) f1 = cyc - t0;
        else if (f2 < 0) f2 = cyc - t0;
      end
      m_prev = m;
      if (i == coll_at) begin
        op_exec = 1'b1; op_rh_wl = ~op_rh_wl; op_phy_addr = 5'h1f;
        op_reg_addr = ~op_reg_addr; op_wr_data = ~op_wr_data;
      end else if (i == coll_at + 1) op_exec = 1'b0;
      @(negedge sys_clk);
    end
    chk({nm, "_done_seen"}, got, 1);
    chk({nm, "_done_cycle"}, cyc - t0, 128 * cd + 1);
    chk({nm, "_busy_in_done"}, sel_busy(w), 0);
    chk({nm, "_busy_gap"}, busy_bad, 0);
    chk({nm, "_first_fall"}, f1, cd);
    chk({nm, "_mdc_period"}, f2 - f1, 2 * cd);
  endtask

  task automatic chk_result(input string nm, input int w, input logic [15:0] ed, input logic ee);
    chk({nm, "_rd_data"}, (w != 0) ? rd2 : op_rd_data, ed);
    chk({nm, "_rd_err"}, (w != 0) ? err2 : op_rd_err, ee);
  endtask

  task automatic chk_frame(input string nm, input int w, input logic [63:0] exp);
    logic [63:0] got;
    int n;
    got = '0;
    n = (w != 0) ? cap2.size() : cap.size();
    chk({nm, "_nbits"}, n, 64);
    for (int i = 0; i < 64 && i < n; i++) got[63 - i] = (w != 0) ? cap2[i] : cap[i];
    chk({nm, "_bits"}, got, exp);
  endtask

  initial begin
    logic [15:0] ed, wd;
    logic        ee, rh;
    logic [4:0]  pa, ra;
    int          nd;

    for (int i = 0; i < 32; i++) begin sl_regs[i] = '0; m_regs[i] = '0; end
    sl_regs[5'h0b] = 16'h55aa;
    m_regs[5'h0b]  = 16'h55aa;

    tbl[0] = '{1'b0, 5'h04, 5'h0a, 16'h1234, 16'h0000, 1'b0};
    tbl[1] = '{1'b1, 5'h04, 5'h0b, 16'h0000, 16'h55aa, 1'b0};
    tbl[2] = '{1'b1, 5'h1f, 5'h0b, 16'h0000, 16'hffff, 1'b1};
    tbl[3] = '{1'b0, 5'h04, 5'h0c, 16'hbeef, 16'hffff, 1'b0};
    tbl[4] = '{1'b1, 5'h04, 5'h0a, 16'h0000, 16'h1234, 1'b0};

    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_mdc", eth_mdc, 1);
    chk("rst_mdio", mdio_bus, 1);
    chk("rst_busy", op_busy, 0);
    chk("rst_done", op_done, 0);
    chk("rst_rd_data", op_rd_data, 16'h0000);
    chk("rst_rd_err", op_rd_err, 0);
    chk("rst_mdc2", mdc2, 1);

    for (int k = 0; k < 5; k++) begin
      drive_exec(0, tbl[k].rh, tbl[k].pa, tbl[k].ra, tbl[k].wd);
      run_frame($sformatf("tbl%0d", k), 0, CD1, -1);
      chk_result($sformatf("tbl%0d", k), 0, tbl[k].ed, tbl[k].ee);
      if (!tbl[k].rh)
        chk_frame($sformatf("tbl%0d", k), 0, wr_frame(tbl[k].pa, tbl[k].ra, tbl[k].wd));
      model_cmd(tbl[k].rh, tbl[k].pa, tbl[k].ra, tbl[k].wd, ed, ee);
    end
    chk("slave_reg0a", sl_regs[5'h0a], 16'h1234);

    // busy collision, then back-to-back exec in the op_done cycle
    drive_exec(0, 1'b0, 5'h04, 5'h0d, 16'ha5a5);
    run_frame("coll", 0, CD1, 400);
    model_cmd(1'b0, 5'h04, 5'h0d, 16'ha5a5, ed, ee);
    chk_result("coll", 0, 16'h1234, 1'b0);
    chk_frame("coll", 0, wr_frame(5'h04, 5'h0d, 16'ha5a5));
    chk("coll_slave_reg", sl_regs[5'h0d], 16'ha5a5);
    drive_exec(0, 1'b1, 5'h04, 5'h0d, 16'h0000);
    run_frame("chain", 0, CD1, -1);
    model_cmd(1'b1, 5'h04, 5'h0d, 16'h0000, ed, ee);
    chk_result("chain", 0, 16'ha5a5, 1'b0);

    // reset while bit 40 is on the wire
    drive_exec(0, 1'b1, 5'h04, 5'h0b, 16'h0000);
    repeat (814) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("midrst_mdc", eth_mdc, 1);
    chk("midrst_mdio", mdio_bus, 1);
    chk("midrst_busy", op_busy, 0);
    chk("midrst_done", op_done, 0);
    chk("midrst_rd_data", op_rd_data, 16'h0000);
    chk("midrst_rd_err", op_rd_err, 0);
    sys_rst = 1'b0;
    m_rd = 16'h0000;
    nd = 0;
    for (int i = 0; i < 600; i++) begin
      if (op_done || op_busy) nd++;
      @(negedge sys_clk);
    end
    chk("midrst_no_activity", nd, 0);
    drive_exec(0, 1'b1, 5'h04, 5'h0a, 16'h0000);
    run_frame("postrst", 0, CD1, -1);
    model_cmd(1'b1, 5'h04, 5'h0a, 16'h0000, ed, ee);
    chk_result("postrst", 0, 16'h1234, 1'b0);

    // random commands against the command-level model
    for (int k = 0; k < 8; k++) begin
      rh = 1'($urandom_range(0, 1));
      pa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h04;
      ra = 5'($urandom_range(0, 15));
      wd = 16'($urandom);
      model_cmd(rh, pa, ra, wd, ed, ee);
      drive_exec(0, rh, pa, ra, wd);
      run_frame($sformatf("rnd%0d", k), 0, CD1, -1);
      chk_result($sformatf("rnd%0d", k), 0, ed, ee);
    end

    // minimum divider
    drive_exec(1, 1'b0, 5'h04, 5'h03, 16'hc3c3);
    run_frame("div2_wr", 1, CD2, -1);
    chk_frame("div2_wr", 1, wr_frame(5'h04, 5'h03, 16'hc3c3));
    chk_result("div2_wr", 1, 16'h0000, 1'b0);
    drive_exec(1, 1'b1, 5'h1f, 5'h03, 16'h0000);
    run_frame("div2_rd", 1, CD2, -1);
    chk_result("div2_rd", 1, 16'hffff, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
